// File: rtl/clk_gen_pkg.sv
// Shared constants for the clock-generator configuration controller:
// FSM state codes, error codes, default ratio and the tolerance compare.
package clk_gen_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_STOP    = 3'd2;
    localparam logic [2:0] ST_LOAD    = 3'd3;
    localparam logic [2:0] ST_RESET   = 3'd4;
    localparam logic [2:0] ST_SETTLE  = 3'd5;
    localparam logic [2:0] ST_MEASURE = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_RATIO = 2'b01,
        ERR_FREQ  = 2'b10
    } err_t;

    localparam logic [15:0] DEF_NUMERATOR   = 16'd15625;
    localparam logic [15:0] DEF_DENOMINATOR = 16'd512;

    typedef struct packed {
        logic [15:0] numerator;
        logic [15:0] denominator;
        logic [15:0] win_len;
        logic [15:0] exp_edges;
        logic [7:0]  tol;
    } cfg_t;

    // Absolute difference taken at 17 bits so no operand ordering can wrap.
    function automatic logic within_tol(input logic [15:0] count,
                                        input logic [15:0] exp_edges,
                                        input logic [7:0]  tol);
        logic [16:0] diff;
        if (count >= exp_edges)
            diff = {1'b0, count} - {1'b0, exp_edges};
        else
            diff = {1'b0, exp_edges} - {1'b0, count};
        return diff <= {9'd0, tol};
    endfunction

endpackage

// File: rtl/clk_gen_cfg_ctrl_meter.sv
// Divided-clock edge meter: 2-flop synchronizer, rising-edge detect and a
// 16-bit saturating edge counter gated by the measurement window.
module clk_edge_meter (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        div_clk,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] edge_count
);

    logic [2:0] sync_q;
    logic       rise;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            sync_q <= '0;
        else
            sync_q <= {sync_q[1:0], div_clk};
    end

    assign rise = sync_q[1] & ~sync_q[2];

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            edge_count <= '0;
        else if (clear)
            edge_count <= '0;
        else if (enable && rise && (edge_count != 16'hFFFF))
            edge_count <= edge_count + 16'd1;
    end

endmodule

// File: rtl/clk_gen_cfg_ctrl.sv
// Clock-generator reconfiguration sequencer: validates a requested ratio,
// stops/reloads/resets the generator, then verifies the divided frequency.
//
// state   | meaning
// IDLE    | waiting for cfg_req
// CHECK   | ratio legality check
// STOP    | generator held stopped
// LOAD    | new ratio driven out
// RESET   | generator config reset asserted
// SETTLE  | generator running, waiting before measurement
// MEASURE | counting divided-clock edges over the window
// DONE    | publish locked/err, return to IDLE
module clk_gen_cfg_ctrl
    import clk_gen_pkg::*;
#(
    parameter int unsigned C_STOP_CYC   = 4,
    parameter int unsigned C_RST_CYC    = 2,
    parameter int unsigned C_SETTLE_CYC = 8
) (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic        I_cfg_req,
    output logic        O_cfg_ack,
    input  logic [15:0] I_numerator,
    input  logic [15:0] I_denominator,
    input  logic [15:0] I_win_len,
    input  logic [15:0] I_exp_edges,
    input  logic [7:0]  I_tol,
    input  logic        I_div_clk,
    output logic        O_gen_stop,
    output logic        O_rst_cfg,
    output logic [15:0] O_numerator,
    output logic [15:0] O_denominator,
    output logic        O_busy,
    output logic        O_locked,
    output logic [1:0]  O_err
);

    localparam logic [15:0] STOP_TC   = 16'(C_STOP_CYC - 1);
    localparam logic [15:0] RST_TC    = 16'(C_RST_CYC - 1);
    localparam logic [15:0] SETTLE_TC = 16'(C_SETTLE_CYC - 1);

    logic [2:0]  state;
    cfg_t        cfg;
    logic [15:0] timer;
    logic [15:0] edge_count;
    logic        meas_ok;

    clk_edge_meter u_meter (
        .sys_clk    (I_sys_clk),
        .rst        (I_rst),
        .div_clk    (I_div_clk),
        .clear      (state == ST_SETTLE),
        .enable     (state == ST_MEASURE),
        .edge_count (edge_count)
    );

    assign meas_ok = within_tol(edge_count, cfg.exp_edges, cfg.tol);
    assign O_busy  = (state != ST_IDLE);

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            state         <= ST_IDLE;
            cfg           <= '0;
            timer         <= '0;
            O_cfg_ack     <= 1'b0;
            O_gen_stop    <= 1'b1;
            O_rst_cfg     <= 1'b1;
            O_numerator   <= DEF_NUMERATOR;
            O_denominator <= DEF_DENOMINATOR;
            O_locked      <= 1'b0;
            O_err         <= ERR_OK;
        end else begin
            O_cfg_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (I_cfg_req) begin
                        cfg.numerator   <= I_numerator;
                        cfg.denominator <= I_denominator;
                        cfg.win_len     <= I_win_len;
                        cfg.exp_edges   <= I_exp_edges;
                        cfg.tol         <= I_tol;
                        O_cfg_ack       <= 1'b1;
                        O_err           <= ERR_OK;
                        state           <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if ((cfg.denominator == 16'd0) || (cfg.denominator >= cfg.numerator)) begin
                        O_err <= ERR_RATIO;
                        state <= ST_DONE;
                    end else begin
                        O_gen_stop <= 1'b1;
                        O_locked   <= 1'b0;
                        timer      <= STOP_TC;
                        state      <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (timer == 16'd0) begin
                        O_numerator   <= cfg.numerator;
                        O_denominator <= cfg.denominator;
                        state         <= ST_LOAD;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_LOAD: begin
                    O_rst_cfg <= 1'b1;
                    timer     <= RST_TC;
                    state     <= ST_RESET;
                end
                ST_RESET: begin
                    if (timer == 16'd0) begin
                        O_rst_cfg  <= 1'b0;
                        O_gen_stop <= 1'b0;
                        timer      <= SETTLE_TC;
                        state      <= ST_SETTLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_SETTLE: begin
                    if (timer == 16'd0) begin
                        if (cfg.win_len == 16'd0) begin
                            state <= ST_DONE;
                        end else begin
                            timer <= cfg.win_len - 16'd1;
                            state <= ST_MEASURE;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_MEASURE: begin
                    if (timer == 16'd0)
                        state <= ST_DONE;
                    else
                        timer <= timer - 16'd1;
                end
                ST_DONE: begin
                    // The counter already holds the final window edge here.
                    if ((O_err == ERR_OK) && ((cfg.win_len == 16'd0) || meas_ok)) begin
                        O_locked <= 1'b1;
                    end else begin
                        O_locked <= 1'b0;
                        if (O_err == ERR_OK)
                            O_err <= ERR_FREQ;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
